slave_req_scheduler: RTL and testbench

- Shares one fixed-order, in-order-reply slave between NUM_REQ NoC requester ports.
- Round-robin grants one request per cycle into a registered slave issue stage.
- Admits a request only while fewer than MAX_OUTSTANDING replies are pending.
- Records each granted request's return dest/vc in an internal tag queue and stamps it onto the matching slave reply. Sits between the NoC translator ports and the slave, replacing the free-running dest-append FIFO with credit-controlled admission.

---
 rtl/sched_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 52 +++++
 rtl/slave_req_scheduler.sv | 137 +++++++++++++
 tb/tb_slave_req_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared helpers for the slave request scheduler.
//   cnt_w(max) : width needed to hold the values 0..max inclusive.
// The tag record {dst, vc} has widths that depend on module parameters, and a
// package cannot take parameters. The typedef therefore lives in
// slave_req_scheduler, built from its own localparams.
package sched_pkg;

    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot grant.
//   clk, rst : clock and synchronous active-low reset (pointer back to 0)
//   en       : grants are allowed this cycle
//   req      : request vector
//   gnt      : one-hot grant, all zero when en is low or there is no request
//   gnt_idx  : index of the winner. Only meaningful while |gnt is set.
// The winner is the first set request at or after the pointer, wrapping
// around. After a grant the pointer moves to the slot just past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      gnt_idx
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        int k;
        k     = 0;
        win   = '0;
        found = 1'b0;
        gnt   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Index wraps by subtraction, so NUM_REQ need not be a power of two.
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found && req[k]) begin
                found = 1'b1;
                win   = PW'(k);
            end
        end
        if (en && found) gnt[win] = 1'b1;
    end

    assign gnt_idx = win;

    always_ff @(posedge clk) begin
        if (!rst)
            ptr <= '0;
        else if (|gnt)
            ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
    end

endmodule

// File: rtl/slave_req_scheduler.sv
// Credit-controlled scheduler that shares one in-order-reply slave between
// NUM_REQ NoC requester ports.
//   clk, rst         : clock and synchronous active-low reset
//   i_req_*          : per-requester valid, payload, return dst and return vc (packed)
//   o_req_ready      : one-hot grant. A request transfers on valid & ready.
//   o_slv_valid/data : registered issue stage toward the slave
//   i_slv_ready      : the slave accepts o_slv_* this cycle
//   i_rsp_valid      : slave reply. Replies come back in issue order.
//   o_rsp_*          : reply qualifier plus the return dst/vc of the oldest
//                      outstanding request
//   o_outstanding    : number of issued requests that have no reply yet
//   o_err            : sticky flag, set by a reply that arrives with nothing
//                      outstanding
module slave_req_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int DATA_WIDTH       = 32,
    parameter int MAX_OUTSTANDING  = 12,
    localparam int CW = cnt_w(MAX_OUTSTANDING),
    localparam int QW = $clog2(MAX_OUTSTANDING),
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        i_req_data,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]     i_req_dst,
    input  logic [NUM_REQ*VC_ADDRESS_WIDTH-1:0]  i_req_vc,
    output logic [NUM_REQ-1:0]                   o_req_ready,
    output logic                                 o_slv_valid,
    output logic [DATA_WIDTH-1:0]                o_slv_data,
    input  logic                                 i_slv_ready,
    input  logic                                 i_rsp_valid,
    output logic                                 o_rsp_valid,
    output logic [ADDRESS_WIDTH-1:0]             o_rsp_dst,
    output logic [VC_ADDRESS_WIDTH-1:0]          o_rsp_vc,
    output logic [CW-1:0]                        o_outstanding,
    output logic                                 o_err
);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0]    dst;
        logic [VC_ADDRESS_WIDTH-1:0] vc;
    } tag_t;

    // Per-requester views of the flat input buses.
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    tag_t [NUM_REQ-1:0]                 req_tag;

    assign req_data = i_req_data;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_tag
        assign req_tag[g].dst = i_req_dst[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign req_tag[g].vc  = i_req_vc[g*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
    end

    logic [CW-1:0]      count;
    logic [QW-1:0]      wr_ptr;
    logic [QW-1:0]      rd_ptr;
    tag_t               tag_q [MAX_OUTSTANDING];
    logic               can_issue;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_fire;
    logic               rsp_fire;
    logic               orphan;

    // Only the registered count is used here. A reply in the same cycle does
    // not free its credit until the next cycle, which keeps the ready path
    // independent of i_rsp_valid.
    assign can_issue = rst && (count < CW'(MAX_OUTSTANDING)) &&
                       (!o_slv_valid || i_slv_ready);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (can_issue),
        .req     (i_req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign o_req_ready = gnt;
    assign gnt_fire    = |gnt;
    assign rsp_fire    = rst && i_rsp_valid && (count != '0);
    assign orphan      = rst && i_rsp_valid && (count == '0);

    assign o_rsp_valid   = rsp_fire;
    assign o_rsp_dst     = tag_q[rd_ptr].dst;
    assign o_rsp_vc      = tag_q[rd_ptr].vc;
    assign o_outstanding = count;

    // Issue register. A new grant overwrites it only when the slave takes the
    // current word or when the register is empty, because can_issue already
    // requires one of those.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_slv_valid <= 1'b0;
            o_slv_data  <= '0;
        end else if (gnt_fire) begin
            o_slv_valid <= 1'b1;
            o_slv_data  <= req_data[gnt_idx];
        end else if (i_slv_ready) begin
            o_slv_valid <= 1'b0;
        end
    end

    // Tag storage is not reset. Entries are only read at positions that were
    // written after the most recent reset, and count guards every read.
    always_ff @(posedge clk) begin
        if (gnt_fire) tag_q[wr_ptr] <= req_tag[gnt_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            o_err  <= 1'b0;
        end else begin
            if (gnt_fire)
                wr_ptr <= (wr_ptr == QW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + QW'(1);
            if (rsp_fire)
                rd_ptr <= (rd_ptr == QW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + QW'(1);
            case ({gnt_fire, rsp_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (orphan) o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_slave_req_scheduler.sv
// Randomised bench for slave_req_scheduler. A queue-based model follows the
// scheduler's behaviour rules and is compared against the DUT every cycle.
module tb_slave_req_scheduler;

    localparam int N   = 4;
    localparam int AW  = 4;
    localparam int VW  = 1;
    localparam int DW  = 32;
    localparam int MAX = 12;
    localparam int CW  = $clog2(MAX + 1);

    logic              clk;
    logic              rst;
    logic [N-1:0]      i_req_valid;
    logic [N*DW-1:0]   i_req_data;
    logic [N*AW-1:0]   i_req_dst;
    logic [N*VW-1:0]   i_req_vc;
    logic [N-1:0]      o_req_ready;
    logic              o_slv_valid;
    logic [DW-1:0]     o_slv_data;
    logic              i_slv_ready;
    logic              i_rsp_valid;
    logic              o_rsp_valid;
    logic [AW-1:0]     o_rsp_dst;
    logic [VW-1:0]     o_rsp_vc;
    logic [CW-1:0]     o_outstanding;
    logic              o_err;

    slave_req_scheduler #(
        .NUM_REQ(N), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW),
        .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk), .rst(rst), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
        .i_req_dst(i_req_dst), .i_req_vc(i_req_vc), .o_req_ready(o_req_ready),
        .o_slv_valid(o_slv_valid), .o_slv_data(o_slv_data), .i_slv_ready(i_slv_ready),
        .i_rsp_valid(i_rsp_valid), .o_rsp_valid(o_rsp_valid), .o_rsp_dst(o_rsp_dst),
        .o_rsp_vc(o_rsp_vc), .o_outstanding(o_outstanding), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pending tags in issue order, round-robin start slot,
    // and the slave-side word.
    typedef struct packed {
        logic [AW-1:0] dst;
        logic [VW-1:0] vc;
    } mtag_t;

    mtag_t         mq[$];
    int            m_ptr;
    bit            m_sv;
    logic [DW-1:0] m_sd;
    bit            m_err;

    // Stimulus for the next cycle.
    bit            rst_v;
    bit [N-1:0]    req_v;
    bit            slv_rdy;
    bit            rsp_v;
    bit            fix_tags;
    logic [DW-1:0] d_a   [N];
    logic [AW-1:0] dst_a [N];
    logic [VW-1:0] vc_a  [N];

    task automatic step();
        int         win;
        bit         can;
        bit         exp_rv;
        logic [N-1:0] exp_rdy;
        mtag_t      t;
        // registered outputs, sampled 1 time unit after the edge
        chk("slv_valid",   64'(o_slv_valid),   64'(m_sv));
        chk("slv_data",    64'(o_slv_data),    64'(m_sd));
        chk("outstanding", 64'(o_outstanding), 64'(mq.size()));
        chk("err",         64'(o_err),         64'(m_err));
        for (int k = 0; k < N; k++) begin
            d_a[k] = $urandom;
            if (!fix_tags) begin
                dst_a[k] = AW'($urandom);
                vc_a[k]  = VW'($urandom);
            end
            i_req_data[k*DW +: DW] = d_a[k];
            i_req_dst[k*AW +: AW]  = dst_a[k];
            i_req_vc[k*VW +: VW]   = vc_a[k];
        end
        rst         = rst_v;
        i_req_valid = req_v;
        i_slv_ready = slv_rdy;
        i_rsp_valid = rsp_v;
        #1;
        win = -1;
        can = rst_v && (mq.size() < MAX) && (!m_sv || slv_rdy);
        if (can)
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (req_v[k] && win < 0) win = k;
            end
        exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
        chk("req_ready", 64'(o_req_ready), 64'(exp_rdy));
        exp_rv = rst_v && rsp_v && (mq.size() > 0);
        chk("rsp_valid", 64'(o_rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("rsp_dst", 64'(o_rsp_dst), 64'(mq[0].dst));
            chk("rsp_vc",  64'(o_rsp_vc),  64'(mq[0].vc));
        end
        if (!rst_v) begin
            mq.delete();
            m_ptr = 0;
            m_sv  = 0;
            m_sd  = '0;
            m_err = 0;
        end else begin
            if (exp_rv) void'(mq.pop_front());
            else if (rsp_v) m_err = 1;
            if (win >= 0) begin
                t.dst = dst_a[win];
                t.vc  = vc_a[win];
                mq.push_back(t);
                m_ptr = (win + 1) % N;
                m_sv  = 1;
                m_sd  = d_a[win];
            end else if (slv_rdy) begin
                m_sv = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit r, input bit [N-1:0] rv, input bit sr, input bit pv);
        rst_v = r; req_v = rv; slv_rdy = sr; rsp_v = pv;
    endtask

    initial begin
        fix_tags = 0;
        m_ptr = 0; m_sv = 0; m_sd = '0; m_err = 0;
        rst = 1'b0; i_req_valid = '1; i_slv_ready = 1'b1; i_rsp_valid = 1'b0;
        i_req_data = '0; i_req_dst = '0; i_req_vc = '0;
        // The first edge only gets the registers out of X. Nothing is checked here.
        @(posedge clk);
        #1;

        // reset held with every requester asking
        set_in(0, '1, 1, 0);
        repeat (3) step();

        // round robin up to the credit limit, hold at full, then one reply
        set_in(1, '1, 1, 0);
        repeat (MAX + 2) step();
        set_in(1, '1, 1, 1);
        step();
        set_in(1, '1, 1, 0);
        repeat (2) step();

        // drain everything
        set_in(1, '0, 1, 1);
        repeat (MAX + 2) step();

        // tag ordering: requester 2 (5,1), then requester 0 (9,0), then two replies
        fix_tags = 1;
        for (int k = 0; k < N; k++) begin dst_a[k] = '0; vc_a[k] = '0; end
        dst_a[2] = 4'd5; vc_a[2] = 1'b1;
        dst_a[0] = 4'd9; vc_a[0] = 1'b0;
        set_in(1, 4'b0100, 1, 0); step();
        set_in(1, 4'b0001, 1, 0); step();
        set_in(1, 4'b0000, 1, 1); step();
        step();
        fix_tags = 0;

        // backpressure: the issue register stays full while the slave stalls
        set_in(1, '1, 1, 0); step();
        set_in(1, '1, 0, 0);
        repeat (4) step();
        set_in(1, '0, 1, 1);
        repeat (4) step();

        // orphan reply with nothing outstanding, then check that err is sticky
        set_in(1, '0, 1, 1); step();
        set_in(1, '0, 1, 0); repeat (2) step();

        // 30 issue/reply pairs cross the pointer wrap
        for (int p = 0; p < 30; p++) begin
            set_in(1, N'(1) << $urandom_range(0, N - 1), 1, 0); step();
            set_in(1, '0, 1, 1); step();
        end
        set_in(1, '0, 1, 0); step();

        // random traffic with an occasional reset
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 59) != 0, N'($urandom),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            step();
        end
        set_in(1, '0, 1, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
